// File: rtl/led_display_rx_pkg.sv
// Shared types and width helpers for the LED display panel receiver.
package led_display_rx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        DUMP = 1'b1
    } rx_state_t;

    typedef logic [2:0] rgb_t;

    typedef struct packed {
        rgb_t top;
        rgb_t bot;
    } pixel_pair_t;

    localparam int DEF_NUM_ROW_PIXELS = 32;
    localparam int DEF_NUM_COL_PIXELS = 64;
    localparam int DEF_SYNC_STAGES    = 2;

    // Width of a counter that must reach n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/led_display_rx_sync.sv
// Multi-stage synchronizer; with EDGE_DET the output is a registered rising-edge
// pulse, otherwise it is the synchronized data delayed to stay aligned with that pulse.
module led_display_rx_sync #(
    parameter int WIDTH    = 1,
    parameter int STAGES   = 2,
    parameter bit EDGE_DET = 1'b0
) (
    input  logic             clk_in,
    input  logic             n_reset_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] last_q;

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
            last_q <= '0;
        end else begin
            sync_q[0] <= d_in;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
            last_q <= sync_q[STAGES-1];
        end
    end

    generate
        if (EDGE_DET) begin : g_edge
            logic [WIDTH-1:0] rise_q;

            always_ff @(posedge clk_in or negedge n_reset_in) begin
                if (!n_reset_in) rise_q <= '0;
                else             rise_q <= sync_q[STAGES-1] & ~last_q;
            end

            assign q_out = rise_q;
        end else begin : g_data
            assign q_out = last_q;
        end
    endgenerate

endmodule

// File: rtl/led_display_rx_phy.sv
// Panel-side receiver: oversamples the panel bus, collects one row of pixel pairs
// per latch and replays it as a per-column pixel write stream.
//
// state | meaning
// IDLE  | shifting bits in, waiting for a latch
// DUMP  | emitting the held row, one column per cycle
module led_display_rx_phy
    import led_display_rx_pkg::*;
#(
    parameter  int NUM_ROW_PIXELS = DEF_NUM_ROW_PIXELS,
    parameter  int NUM_COL_PIXELS = DEF_NUM_COL_PIXELS,
    parameter  int SYNC_STAGES    = DEF_SYNC_STAGES,
    localparam int ROW_W          = $clog2(NUM_ROW_PIXELS/2),
    localparam int COL_W          = $clog2(NUM_COL_PIXELS)
) (
    input  logic             clk_in,
    input  logic             n_reset_in,
    input  logic             bclk_in,
    input  logic             latch_in,
    input  logic [ROW_W-1:0] addr_in,
    input  logic [2:0]       rgb_top_in,
    input  logic [2:0]       rgb_bot_in,
    input  logic             clear_err_in,
    output logic             pix_valid_out,
    output logic [ROW_W-1:0] pix_row_out,
    output logic [COL_W-1:0] pix_col_out,
    output logic [2:0]       pix_rgb_top_out,
    output logic [2:0]       pix_rgb_bot_out,
    output logic             row_done_out,
    output logic             overrun_out,
    output logic             len_err_out
);

    localparam int CNT_W = cnt_width(NUM_COL_PIXELS);
    localparam int DAT_W = ROW_W + 6;

    logic             bclk_rise;
    logic             latch_rise;
    logic [DAT_W-1:0] data_s;
    logic [ROW_W-1:0] addr_s;
    pixel_pair_t      pair_s;

    led_display_rx_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .EDGE_DET(1'b1)) u_sync_bclk (
        .clk_in     (clk_in),
        .n_reset_in (n_reset_in),
        .d_in       (bclk_in),
        .q_out      (bclk_rise)
    );

    led_display_rx_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .EDGE_DET(1'b1)) u_sync_latch (
        .clk_in     (clk_in),
        .n_reset_in (n_reset_in),
        .d_in       (latch_in),
        .q_out      (latch_rise)
    );

    led_display_rx_sync #(.WIDTH(DAT_W), .STAGES(SYNC_STAGES), .EDGE_DET(1'b0)) u_sync_data (
        .clk_in     (clk_in),
        .n_reset_in (n_reset_in),
        .d_in       ({addr_in, rgb_top_in, rgb_bot_in}),
        .q_out      (data_s)
    );

    assign addr_s = data_s[DAT_W-1:6];
    assign pair_s = pixel_pair_t'(data_s[5:0]);

    rx_state_t        state_q, state_d;
    pixel_pair_t      shift_buf [NUM_COL_PIXELS];
    pixel_pair_t      hold_buf  [NUM_COL_PIXELS];
    logic [CNT_W-1:0] bit_cnt_q;
    logic             extra_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic             overrun_q;
    logic             len_err_q;
    logic             row_ok;
    logic             good_latch;
    logic             last_col;

    assign row_ok     = (bit_cnt_q == CNT_W'(NUM_COL_PIXELS)) && !extra_q;
    assign good_latch = latch_rise && (state_q == IDLE) && row_ok;
    assign last_col   = (col_q == COL_W'(NUM_COL_PIXELS - 1));

    always_comb begin
        state_d         = state_q;
        pix_valid_out   = 1'b0;
        pix_row_out     = '0;
        pix_col_out     = '0;
        pix_rgb_top_out = '0;
        pix_rgb_bot_out = '0;
        row_done_out    = 1'b0;
        case (state_q)
            IDLE: begin
                if (good_latch) state_d = DUMP;
            end
            DUMP: begin
                pix_valid_out   = 1'b1;
                pix_row_out     = row_q;
                pix_col_out     = col_q;
                pix_rgb_top_out = hold_buf[col_q].top;
                pix_rgb_bot_out = hold_buf[col_q].bot;
                row_done_out    = last_col;
                if (last_col) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign overrun_out = overrun_q;
    assign len_err_out = len_err_q;

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state_q <= IDLE;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= (state_q == DUMP && !last_col) ? col_q + COL_W'(1) : '0;
        end
    end

    // A bclk rise coinciding with a latch belongs to the row that starts at that latch.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            for (int i = 0; i < NUM_COL_PIXELS; i++) shift_buf[i] <= '0;
            bit_cnt_q <= '0;
            extra_q   <= 1'b0;
        end else if (latch_rise) begin
            extra_q   <= 1'b0;
            bit_cnt_q <= bclk_rise ? CNT_W'(1) : '0;
            if (bclk_rise) shift_buf[0] <= pair_s;
        end else if (bclk_rise) begin
            if (bit_cnt_q < CNT_W'(NUM_COL_PIXELS)) begin
                shift_buf[bit_cnt_q[COL_W-1:0]] <= pair_s;
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end else begin
                extra_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            for (int i = 0; i < NUM_COL_PIXELS; i++) hold_buf[i] <= '0;
            row_q <= '0;
        end else if (good_latch) begin
            hold_buf <= shift_buf;
            row_q    <= addr_s;
        end
    end

    // Error events take priority over a simultaneous clear.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            overrun_q <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            if (latch_rise && state_q == DUMP) overrun_q <= 1'b1;
            else if (clear_err_in)             overrun_q <= 1'b0;
            if (latch_rise && state_q == IDLE && !row_ok) len_err_q <= 1'b1;
            else if (clear_err_in)                        len_err_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_display_rx_phy.sv
// Directed/randomized bench for led_display_rx_phy with a row-level reference model.
module tb_led_display_rx_phy;

    localparam int NROW = 32;
    localparam int NCOL = 64;
    localparam int SYNC = 2;

    logic       clk_in = 1'b0;
    logic       n_reset_in = 1'b0;
    logic       bclk_in = 1'b0;
    logic       latch_in = 1'b0;
    logic [3:0] addr_in = '0;
    logic [2:0] rgb_top_in = '0;
    logic [2:0] rgb_bot_in = '0;
    logic       clear_err_in = 1'b0;
    logic       pix_valid_out;
    logic [3:0] pix_row_out;
    logic [5:0] pix_col_out;
    logic [2:0] pix_rgb_top_out;
    logic [2:0] pix_rgb_bot_out;
    logic       row_done_out;
    logic       overrun_out;
    logic       len_err_out;

    led_display_rx_phy #(.NUM_ROW_PIXELS(NROW), .NUM_COL_PIXELS(NCOL), .SYNC_STAGES(SYNC)) dut (
        .clk_in          (clk_in),
        .n_reset_in      (n_reset_in),
        .bclk_in         (bclk_in),
        .latch_in        (latch_in),
        .addr_in         (addr_in),
        .rgb_top_in      (rgb_top_in),
        .rgb_bot_in      (rgb_bot_in),
        .clear_err_in    (clear_err_in),
        .pix_valid_out   (pix_valid_out),
        .pix_row_out     (pix_row_out),
        .pix_col_out     (pix_col_out),
        .pix_rgb_top_out (pix_rgb_top_out),
        .pix_rgb_bot_out (pix_rgb_bot_out),
        .row_done_out    (row_done_out),
        .overrun_out     (overrun_out),
        .len_err_out     (len_err_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int     row;
        int     col;
        int     top;
        int     bot;
        bit     done;
        longint cyc;
    } pix_t;

    pix_t   obs_q[$];
    longint cyc = 0;
    int     tests = 0;
    int     fails = 0;
    int     tx_top [NCOL+1];
    int     tx_bot [NCOL+1];
    int     exp_frame [NROW][NCOL];
    int     obs_frame [NROW][NCOL];

    always @(negedge clk_in) begin
        cyc++;
        if (pix_valid_out)
            obs_q.push_back('{int'(pix_row_out), int'(pix_col_out), int'(pix_rgb_top_out),
                              int'(pix_rgb_bot_out), row_done_out, cyc});
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint observed, input longint expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #2;
        end
    endtask

    // 4 clk periods per bit: data leads the bclk rise by one cycle, bclk high 2 / low 2.
    task automatic send_bit(input int t, input int b);
        logic [2:0] tv, bv;
        tv = 3'(t);
        bv = 3'(b);
        rgb_top_in = tv;
        rgb_bot_in = bv;
        tick(1);
        bclk_in = 1'b1;
        tick(2);
        bclk_in = 1'b0;
        tick(1);
    endtask

    task automatic send_row(input int n);
        for (int i = 0; i < n; i++) send_bit(tx_top[i], tx_bot[i]);
    endtask

    task automatic fill_random();
        for (int i = 0; i <= NCOL; i++) begin
            tx_top[i] = int'($urandom_range(7, 0));
            tx_bot[i] = int'($urandom_range(7, 0));
        end
    endtask

    task automatic do_latch(input int addr, output longint lcyc);
        addr_in = 4'(addr);
        tick(1);
        latch_in = 1'b1;
        lcyc = cyc;
        tick(2);
        latch_in = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_err_in = 1'b1;
        tick(1);
        clear_err_in = 1'b0;
    endtask

    // A good row appears SYNC+1 cycles after the latch pin plus one cycle, one column per cycle.
    task automatic check_row(input string tag, input int addr, input longint lcyc);
        pix_t p;
        chk({tag, "_count"}, obs_q.size(), NCOL);
        if (obs_q.size() == NCOL) begin
            for (int k = 0; k < NCOL; k++) begin
                p = obs_q[k];
                chk({tag, "_row"},  p.row, addr);
                chk({tag, "_col"},  p.col, k);
                chk({tag, "_top"},  p.top, tx_top[k]);
                chk({tag, "_bot"},  p.bot, tx_bot[k]);
                chk({tag, "_done"}, p.done, (k == NCOL-1) ? 1 : 0);
                chk({tag, "_cyc"},  p.cyc, lcyc + SYNC + 3 + k);
            end
        end
        obs_q.delete();
    endtask

    function automatic longint all_outs();
        return longint'({pix_valid_out, row_done_out, overrun_out, len_err_out, pix_row_out,
                         pix_col_out, pix_rgb_top_out, pix_rgb_bot_out});
    endfunction

    initial begin
        longint lcyc, lcyc2;
        bit     found;
        int     addr;

        // reset state
        tick(3);
        chk("reset_outputs", all_outs(), 0);
        n_reset_in = 1'b1;
        tick(4);
        chk("idle_outputs", all_outs(), 0);

        // nominal row
        for (int c = 0; c < NCOL; c++) begin
            tx_top[c] = c % 8;
            tx_bot[c] = (c + 3) % 8;
        end
        send_row(NCOL);
        do_latch(5, lcyc);
        tick(80);
        check_row("nominal", 5, lcyc);
        chk("nominal_len_err", len_err_out, 0);
        chk("nominal_overrun", overrun_out, 0);

        // short row
        fill_random();
        send_row(NCOL - 1);
        do_latch(3, lcyc);
        tick(80);
        chk("short_no_valid", obs_q.size(), 0);
        chk("short_len_err", len_err_out, 1);
        chk("short_overrun", overrun_out, 0);
        pulse_clear();
        chk("short_cleared", len_err_out, 0);

        // long row
        fill_random();
        send_row(NCOL + 1);
        do_latch(6, lcyc);
        tick(80);
        chk("long_no_valid", obs_q.size(), 0);
        chk("long_len_err", len_err_out, 1);
        pulse_clear();
        chk("long_cleared", len_err_out, 0);

        // good row right after a long one
        fill_random();
        send_row(NCOL);
        do_latch(9, lcyc);
        tick(80);
        check_row("after_long", 9, lcyc);
        chk("after_long_len_err", len_err_out, 0);

        // overrun: second latch 10 cycles into the dump
        fill_random();
        send_row(NCOL);
        do_latch(2, lcyc);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1);
            if (pix_valid_out) found = 1'b1;
        end
        chk("overrun_dump_started", found, 1);
        tick(9);
        do_latch(7, lcyc2);
        tick(80);
        check_row("overrun_first", 2, lcyc);
        chk("overrun_flag", overrun_out, 1);
        tick(80);
        chk("overrun_no_second", obs_q.size(), 0);

        // reset mid-dump (overrun still sticky, must clear too)
        fill_random();
        send_row(NCOL);
        do_latch(11, lcyc);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk_in);
            if (pix_valid_out && pix_col_out == 6'd20) found = 1'b1;
        end
        chk("rst_reached_col20", found, 1);
        #1 n_reset_in = 1'b0;
        #1 chk("rst_outputs_zero", all_outs(), 0);
        tick(3);
        n_reset_in = 1'b1;
        obs_q.delete();
        tick(80);
        chk("rst_no_valid_after", obs_q.size(), 0);
        fill_random();
        send_row(NCOL);
        do_latch(4, lcyc);
        tick(80);
        check_row("rst_recover", 4, lcyc);

        // full frame at 25 MHz bclk, rows in a scrambled order
        for (int r = 0; r < NROW; r++)
            for (int c = 0; c < NCOL; c++) begin
                exp_frame[r][c] = -1;
                obs_frame[r][c] = -1;
            end
        for (int r = 0; r < NROW/2; r++) begin
            addr = (r * 7) % (NROW/2);
            fill_random();
            for (int c = 0; c < NCOL; c++) begin
                exp_frame[addr][c]          = tx_top[c];
                exp_frame[addr + NROW/2][c] = tx_bot[c];
            end
            send_row(NCOL);
            do_latch(addr, lcyc);
        end
        tick(80);
        chk("frame_count", obs_q.size(), (NROW/2) * NCOL);
        foreach (obs_q[i]) begin
            obs_frame[obs_q[i].row][obs_q[i].col]          = obs_q[i].top;
            obs_frame[obs_q[i].row + NROW/2][obs_q[i].col] = obs_q[i].bot;
        end
        obs_q.delete();
        for (int r = 0; r < NROW; r++)
            for (int c = 0; c < NCOL; c++)
                chk($sformatf("frame_r%0d_c%0d", r, c), obs_frame[r][c], exp_frame[r][c]);
        chk("frame_len_err", len_err_out, 0);
        chk("frame_overrun", overrun_out, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
